// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control encodings (same as the control unit) and
// the state encoding of the iterative multiply/divide engine.
package cpu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_MUL = 4'b0100;
  localparam logic [3:0] ALU_DIV = 4'b0101;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } mdState_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) engine producing a
// double-width hi/lo result through a start/busy/done handshake.
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // MIN maps to the unsigned value 2^(WIDTH-1), which still fits in WIDTH bits.
  function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  mdState_e         state;
  logic             isDiv;
  logic             negRes;
  logic             negRem;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   rem;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   remDiff;
  logic             takeBit;
  logic             acceptOp;

  // A set top remainder bit means the shifted value exceeds any divisor.
  always_comb begin
    mulSum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, absA} : '0);
    remShift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    remDiff  = remShift - {1'b0, absB};
    takeBit  = ~remDiff[WIDTH] | rem[WIDTH];
    acceptOp = start && ((alu_ctrl == ALU_MUL) || (alu_ctrl == ALU_DIV));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      isDiv       <= 1'b0;
      negRes      <= 1'b0;
      negRem      <= 1'b0;
      absA        <= '0;
      absB        <= '0;
      quo         <= '0;
      rem         <= '0;
      prod        <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acceptOp) begin
            isDiv       <= (alu_ctrl == ALU_DIV);
            negRes      <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            negRem      <= op_a[WIDTH-1];
            absA        <= absVal(op_a);
            absB        <= absVal(op_b);
            quo         <= absVal(op_a);
            rem         <= '0;
            prod        <= {{WIDTH{1'b0}}, absVal(op_b)};
            count       <= '0;
            div_by_zero <= 1'b0;
            // Divide by zero skips the datapath entirely and reports next cycle.
            if ((alu_ctrl == ALU_DIV) && (op_b == '0)) begin
              div_by_zero <= 1'b1;
              lo          <= '1;
              hi          <= op_a;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (isDiv) begin
            rem <= takeBit ? remDiff : remShift;
            quo <= {quo[WIDTH-2:0], takeBit};
          end else begin
            prod <= {mulSum, prod[WIDTH-1:1]};
          end
          count <= count + 1'b1;
          if (count == LAST) begin
            state <= FIXUP;
          end
        end
        FIXUP: begin
          if (isDiv) begin
            lo <= negRes ? -quo : quo;
            hi <= negRem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          end else begin
            {hi, lo} <= negRes ? -prod : prod;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results from native 128-bit signed
// arithmetic are queued at stimulus time and compared when done pulses.
module tb_muldiv_unit;
  import cpu_pkg::*;

  localparam int W = 64;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
    int           busyCyc;
  } expT;

  logic         clk;
  logic         rst;
  logic         start;
  logic [3:0]   aluCtrl;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         divByZero;

  expT expQ[$];
  int  checks = 0;
  int  errors = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .alu_ctrl   (aluCtrl),
    .op_a       (opA),
    .op_b       (opB),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .div_by_zero(divByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic expT model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    expT e;
    logic signed [2*W-1:0] sa, sbv, p, q, r;
    sa  = {{W{a[W-1]}}, a};
    sbv = {{W{b[W-1]}}, b};
    e.dbz = 1'b0;
    e.lat = W + 2;
    e.busyCyc = W + 1;
    if (op == ALU_MUL) begin
      p = sa * sbv;
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
    end else if (b == '0) begin
      e.hi = a;
      e.lo = '1;
      e.dbz = 1'b1;
      e.lat = 1;
      e.busyCyc = 0;
    end else begin
      q = sa / sbv;
      r = sa % sbv;
      e.hi = r[W-1:0];
      e.lo = q[W-1:0];
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [2*W-1:0] actual, input logic [2*W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    aluCtrl = op;
    opA     = a;
    opB     = b;
    start   = 1'b1;
    expQ.push_back(model(op, a, b));
  endtask

  // Waits for done with a cycle budget; optionally re-strobes start mid-operation.
  task automatic waitDone(input int pokeCycle);
    expT e;
    int  busyCycles = 0;
    int  lat = 0;
    bit  seen = 0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 200 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        if (expQ.size() > 0) checkOutput("dbzAtAccept", 128'(divByZero), 128'(expQ[0].dbz));
      end
      if (busy) busyCycles++;
      if (done) begin
        seen = 1;
        lat  = cyc;
      end else if (cyc == pokeCycle) begin
        start   = 1'b1;
        aluCtrl = ALU_DIV;
        opA     = 64'h7777;
        opB     = 64'h3;
      end else if (cyc == pokeCycle + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!seen) checkOutput("doneTimeout", 128'(0), 128'(1));
    if (expQ.size() == 0) begin
      checkOutput("scoreboardEmpty", 128'(0), 128'(1));
    end else begin
      e = expQ.pop_front();
      checkOutput("latency", 128'(lat), 128'(e.lat));
      checkOutput("busyCycles", 128'(busyCycles), 128'(e.busyCyc));
      checkOutput("hi", 128'(hi), 128'(e.hi));
      checkOutput("lo", 128'(lo), 128'(e.lo));
      checkOutput("divByZero", 128'(divByZero), 128'(e.dbz));
    end
    @(negedge clk);
    checkOutput("donePulse", 128'(done), 128'(0));
  endtask

  task automatic runOp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int poke);
    applyStimulus(op, a, b);
    waitDone(poke);
  endtask

  initial begin
    int hits;
    logic [W-1:0] ra, rb;
    rst     = 1'b1;
    start   = 1'b0;
    aluCtrl = ALU_NOP;
    opA     = '0;
    opB     = '0;
    repeat (2) @(negedge clk);
    checkOutput("resetBusy", 128'(busy), 128'(0));
    checkOutput("resetDone", 128'(done), 128'(0));
    checkOutput("resetHiLo", {hi, lo}, 128'(0));
    checkOutput("resetDbz", 128'(divByZero), 128'(0));
    rst = 1'b0;

    runOp(ALU_MUL, -64'sd3, 64'sd5, 0);
    runOp(ALU_DIV, -64'sd7, 64'sd2, 0);
    runOp(ALU_DIV, 64'd10, 64'd0, 0);
    runOp(ALU_MUL, 64'd123, -64'sd4, 0);
    runOp(ALU_DIV, MINV, -64'sd1, 0);
    runOp(ALU_MUL, MINV, MINV, 0);
    runOp(ALU_DIV, 64'd9, -64'sd4, 0);
    runOp(ALU_MUL, 64'h1234, -64'sh777, 10);

    // Unsupported ALU code in IDLE must leave the engine untouched.
    @(negedge clk);
    aluCtrl = ALU_ADD;
    opA     = 64'd55;
    opB     = 64'd66;
    start   = 1'b1;
    hits    = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || done) hits++;
    end
    checkOutput("ignoredCode", 128'(hits), 128'(0));

    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom};
      rb = (i % 2 == 0) ? {$urandom, $urandom} : 64'($signed($urandom_range(0, 2000)) - 1000);
      runOp((i < 3) ? ALU_MUL : ALU_DIV, ra, rb, 0);
    end

    // Asynchronous reset partway through a divide.
    applyStimulus(ALU_DIV, 64'd1000, 64'd7);
    @(posedge clk);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    checkOutput("rstBusy", 128'(busy), 128'(0));
    checkOutput("rstDone", 128'(done), 128'(0));
    checkOutput("rstHiLo", {hi, lo}, 128'(0));
    void'(expQ.pop_back());
    @(negedge clk);
    rst  = 1'b0;
    hits = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done) hits++;
    end
    checkOutput("noDoneAfterRst", 128'(hits), 128'(0));
    runOp(ALU_MUL, 64'd6, 64'd7, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative signed multiply/divide engine sitting directly downstream of the control unit.
- Consumes the decoded ALU operation (ALU_MUL / ALU_DIV) plus the two register operands.
- Produces a double-width result (hi/lo) over multiple cycles, using a start/busy/done handshake.
- The datapath stalls PC update and write-back while busy is high.

Parameters:
- WIDTH, 64, operand width in bits; must be even and at least 8.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset: asynchronous assert, active-high; clears all state.
- start  input  1  request strobe; sampled only in IDLE.
- alu_ctrl  input  4  ALU control code: 4'b0100 = MUL, 4'b0101 = DIV; any other code is ignored.
- op_a  input  WIDTH  rs operand; the dividend for DIV. Two's complement.
- op_b  input  WIDTH  rt operand; the divisor for DIV. Two's complement.
- busy  output  1  high while an operation is in flight; the datapath stalls on it.
- done  output  1  one-cycle pulse when hi/lo become valid.
- hi  output  WIDTH  MUL: product[2*WIDTH-1:WIDTH]; DIV: remainder.
- lo  output  WIDTH  MUL: product[WIDTH-1:0]; DIV: quotient.
- div_by_zero  output  1  set on DIV with op_b==0; held until the next accepted start.

Behaviour:
- Reset:
  - All outputs are 0 and the state is IDLE.
  - Asserting rst mid-operation aborts immediately: no done pulse; hi/lo are cleared to 0.
- States: IDLE, CALC, FIXUP, DONE.
- Acceptance: start=1 in IDLE with a MUL/DIV code latches op_a, op_b and the op.
  - It also clears div_by_zero.
  - busy goes high in the next cycle.
  - start with any other code, or start in any state other than IDLE, is ignored with no side effects.
- Sign handling:
  - Absolute values of both operands are latched at acceptance.
  - neg_res = sign(a) XOR sign(b); neg_rem = sign(a).
  - |MIN| is taken as the unsigned value 2^(WIDTH-1).
- MUL:
  - Shift-add over 2*WIDTH-bit accumulation, one multiplier bit per cycle.
  - CALC lasts exactly WIDTH cycles.
- DIV:
  - Restoring division, one quotient bit per cycle; CALC lasts exactly WIDTH cycles.
  - Remainder register is WIDTH+1 bits internally.
- FIXUP (1 cycle):
  - MUL: negate the 2*WIDTH product if neg_res.
  - DIV: negate the quotient if neg_res and the remainder if neg_rem.
  - Write hi/lo.
- DONE (1 cycle): done=1, busy=0; then return to IDLE.
  - A start presented during DONE is ignored.
- Latency:
  - Start accepted at edge 0; busy=1 during cycles 1..WIDTH+1.
  - done=1 in cycle WIDTH+2. For WIDTH=64 that is cycle 66.
- Divide by zero:
  - From acceptance, go directly to DONE, skipping CALC and FIXUP.
  - done=1 in cycle 1; busy=1 for no cycles.
  - lo = all ones, hi = op_a unmodified, div_by_zero=1.
- Overflow: MIN / -1 yields lo=MIN and hi=0 via two's-complement wrap, with no flag.
- hi/lo hold their last value until the FIXUP of the next operation, or until rst.
- Multiply is always the full 2*WIDTH-bit signed product; it never overflows.

Decomposition:
- Shared package cpu_pkg:
  - ALU control localparams ALU_ADD..ALU_DIV and ALU_NOP, identical encodings to the control unit.
  - muldiv state encoding: IDLE=2'd0, CALC=2'd1, FIXUP=2'd2, DONE=2'd3.
- Single module: the per-cycle step (shift-add / restore-subtract) lives inline in the CALC branch.
- The operation counter is clog2(WIDTH)+1 bits.
- No sub-module is required.

Test Plan:
1. MUL: op_a=-3, op_b=5 -> done at cycle 66; hi=0xFFFF_FFFF_FFFF_FFFF, lo=0xFFFF_FFFF_FFFF_FFF1; busy high for cycles 1..65.
2. DIV: op_a=-7, op_b=2 -> done at cycle 66; lo=0xFFFF_FFFF_FFFF_FFFD (-3), hi=0xFFFF_FFFF_FFFF_FFFF (-1), div_by_zero=0.
3. DIV by zero: op_a=10, op_b=0 -> done at cycle 1; lo=all ones, hi=10, div_by_zero=1; the next accepted MUL clears div_by_zero.
4. Overflow and full width:
   - DIV op_a=0x8000_0000_0000_0000, op_b=-1 -> lo=0x8000_0000_0000_0000, hi=0.
   - MUL MIN*MIN -> hi=0x4000_0000_0000_0000, lo=0.
5. Handshake robustness:
   - start pulsed at cycle 10 of a MUL -> ignored; results match the original operands.
   - start with alu_ctrl=4'b0000 in IDLE -> busy stays 0 and no done pulse.
6. Reset mid-operation: rst at cycle 30 of a DIV -> busy, done, hi and lo go 0 asynchronously; no done pulse afterwards; a new MUL 6*7 completes with lo=42, hi=0.
